// File: rtl/updown_modulo.sv
// Up/down modulo counter with range 0..lim, variable step, synchronous load and terminal-count flag.
// Optional clamp-at-bound mode (sat input) is compiled in with UPDOWN_MODULO_SATURATE_EN.
module updown_modulo #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              ld,
    input  logic [WIDTH-1:0]  d,
    input  logic              ud,
    input  logic [STEP_W-1:0] step,
`ifdef UPDOWN_MODULO_SATURATE_EN
    input  logic              sat,
`endif
    input  logic [WIDTH-1:0]  lim,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              zero,
    output logic              at_lim
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             sat_mode;

`ifdef UPDOWN_MODULO_SATURATE_EN
    assign sat_mode = sat;
`else
    assign sat_mode = 1'b0;
`endif

    // All arithmetic is one bit wider than the counter so lim = 2^WIDTH-1 cannot overflow.
    logic [WIDTH:0] cnt_x, lim_x, lim_p1, step_x, eff_step;
    logic [WIDTH:0] up_sum, up_raw, up_wrap, dn_wrap;
    logic           lim_zero, out_of_range, step_nz;
    logic           up_cross, dn_cross, up_cross_raw, dn_cross_raw;

    always_comb begin
        cnt_x        = {1'b0, count_q};
        lim_x        = {1'b0, lim};
        lim_p1       = lim_x + 1'b1;
        step_x       = (WIDTH+1)'(step);
        eff_step     = (step_x > lim_x) ? lim_x : step_x;
        lim_zero     = (lim == '0);
        out_of_range = (count_q > lim);
        step_nz      = (step != '0);

        up_sum       = cnt_x + eff_step;
        up_cross     = (up_sum > lim_x);
        up_wrap      = up_sum - lim_p1;
        dn_cross     = (eff_step > cnt_x);
        dn_wrap      = cnt_x + lim_p1 - eff_step;

        // Clamping compares the unreduced step so an oversized step still registers as a crossing.
        up_raw       = cnt_x + step_x;
        up_cross_raw = (up_raw > lim_x);
        dn_cross_raw = (step_x > cnt_x);
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (ce) begin
            if (ld) begin
                count_d = (d > lim) ? lim : d;
            end else if (out_of_range) begin
                count_d = ud ? '0 : lim;
            end else if (step_nz) begin
                if (lim_zero) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else if (sat_mode) begin
                    if (ud) begin
                        if (up_cross_raw) begin
                            count_d = lim;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = up_raw[WIDTH-1:0];
                        end
                    end else begin
                        if (dn_cross_raw) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q - WIDTH'(step);
                        end
                    end
                end else if (ud) begin
                    if (up_cross) begin
                        count_d = up_wrap[WIDTH-1:0];
                        tc_d    = 1'b1;
                    end else begin
                        count_d = up_sum[WIDTH-1:0];
                    end
                end else begin
                    if (dn_cross) begin
                        count_d = dn_wrap[WIDTH-1:0];
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q - eff_step[WIDTH-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign q      = count_q;
    assign tc     = tc_q;
    assign zero   = (count_q == '0);
    assign at_lim = (count_q == lim);

endmodule

// File: doc/updown_modulo.md
UPDOWN_MODULO -- requirements
Module: updown_modulo

Interface
REQ-001 Parameter WIDTH, default 8, counter and limit width in bits (WIDTH >= 2).
REQ-002 Parameter STEP_W, default 4, step input width in bits (1 <= STEP_W <= WIDTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ce  input  1  count/load enable; no state change (except rst) when low.
REQ-006 ld  input  1  synchronous load request, qualified by ce.
REQ-007 d  input  WIDTH  load value.
REQ-008 ud  input  1  direction: 1 = up, 0 = down.
REQ-009 step  input  STEP_W  increment/decrement magnitude per enabled cycle.
REQ-010 lim  input  WIDTH  inclusive upper bound; count range is 0..lim (modulus lim+1).
REQ-011 q  output  WIDTH  registered count value.
REQ-012 tc  output  1  registered terminal-count pulse, high one cycle after a boundary crossing.
REQ-013 zero  output  1  combinational, high when q == 0.
REQ-014 at_lim  output  1  combinational, high when q == lim.

Function
REQ-015 Priority per edge: rst, then (ld & ce), then count (ce), else hold q and clear tc.
REQ-016 ld with ce low is ignored; q holds.
REQ-017 Load: q <= d if d <= lim, else q <= lim; tc <= 0.
REQ-018 Effective step s = min(step zero-extended to WIDTH, lim); step == 0 holds q, tc <= 0.
REQ-019 Up count: compute q+s in WIDTH+1 bits; if <= lim then q <= q+s, tc <= 0; else q <= q+s-(lim+1), tc <= 1.
REQ-020 Down count: if s <= q then q <= q-s, tc <= 0; else q <= q+(lim+1)-s, tc <= 1.
REQ-021 All intermediate arithmetic is WIDTH+1 bits; no overflow at lim = 2^WIDTH-1.
REQ-022 lim == 0: q is held at 0; every enabled count cycle with step != 0 asserts tc.
REQ-023 Out-of-range state (lim lowered below q): next enabled count cycle forces q <= 0 when ud=1 or q <= lim when ud=0, tc <= 0; ld takes priority.
REQ-024 Count latency one cycle: q reflects the ce cycle's result on the following edge; tc coincides with that q.
REQ-025 ud, step and lim changes take effect on the same edge they are sampled; no pipelining.

Reset
REQ-026 On rst high at a rising edge: q <= 0, tc <= 0, regardless of ce/ld.
REQ-027 rst mid-count discards the pending operation; counting resumes from 0 on the first enabled edge after rst falls.
REQ-028 zero = 1 and at_lim = (lim == 0) while in reset.

Configuration
REQ-029 Macro UPDOWN_MODULO_SATURATE_EN, when defined, adds input port sat (1 bit, after step).
REQ-030 With the macro and sat = 1: up crossing gives q <= lim, down crossing gives q <= 0, tc <= 1 on the clamping edge; holding at the bound with further counts keeps tc = 1.
REQ-031 With the macro and sat = 0, or without the macro (no sat port): wrap behaviour per REQ-019/REQ-020 only.

Verification
REQ-032 WIDTH=8, lim=9, step=1, ud=1, ce=1 from q=0 for 10 cycles -> q 1..9 then 0; tc high only with q=0.
REQ-033 lim=9, q=2, step=5, ud=0, ce=1 -> q=7, tc=1; next step=3 -> q=4, tc=0.
REQ-034 lim=255, q=250, step=15, ud=1 -> q=9, tc=1 (no overflow); ld=1, ce=0, d=3 -> q holds 9.
REQ-035 lim=9, ld=1, ce=1, d=20 -> q=9; then lim=5, ud=1, ce=1 -> q=0, tc=0.
REQ-036 q=7 mid-count, rst=1 one edge with ld=1, ce=1 -> q=0, tc=0, zero=1; next edge count up step=2 -> q=2.
REQ-037 With UPDOWN_MODULO_SATURATE_EN, sat=1, lim=9, q=8, step=4, ud=1 -> q=9, tc=1; repeat -> q=9, tc=1; ud=0, step=12 -> q=0, tc=1.
